// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Optional performance counters are enabled with the PREFETCH_PERF_EN macro.
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } pf_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } pf_entry_t;

  localparam logic [31:0] INST_BYTES = 32'd4;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Bus bundle between the prefetch queue, instruction memory, decode and fetch.
// Handshakes: a memory request transfers on the cycle imem_req & imem_gnt are both
// high, and the request holds imem_addr until then; an instruction transfers on the
// cycle inst_valid & inst_ready are both high, and the entry stays at the head until then.
interface fetch_prefetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4,
    input  imem_gnt, imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4,
    output imem_gnt, imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_prefetch_queue_pf_fifo.sv
// Circular FIFO of {instruction, pc} entries with flush; the head is read straight
// from storage so the fetch outputs carry no extra register stage.
module pf_fifo
  import prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  pf_entry_t                push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output pf_entry_t                head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  pf_entry_t     mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Pop on empty is ignored; a push into a full FIFO only lands if a pop frees a slot.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding memory request, FIFO of fetched
// words, redirect flush. Define PREFETCH_PERF_EN to add stall/flush counters.
module fetch_prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  fetch_prefetch_queue_if.master  bus,
  output pf_state_t               dbg_state_o
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  pf_state_t     state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   pending_pc_q;
  logic [31:0]   imem_addr_q;
  logic          imem_req_q;

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after;
  pf_entry_t     fifo_head;
  pf_entry_t     push_entry;
  logic          gnt, ack, redirect, push, pop, credit, inst_valid;
  logic [31:0]   target, fetch_pc_inc;

  assign gnt          = imem_req_q && bus.imem_gnt;
  assign ack          = bus.imem_ack;
  assign redirect     = bus.redirect;
  assign target       = bus.redirect_pc & ~32'd3;
  assign fetch_pc_inc = next_pc(fetch_pc_q);
  assign inst_valid   = (fifo_count != '0);

  assign push       = (state_q == WAIT) && ack && !redirect;
  assign pop        = inst_valid && bus.inst_ready && !redirect;
  assign push_entry = '{inst: bus.imem_rdata, pc: pending_pc_q};

  // Credit looks at the occupancy after this cycle's push/pop; in WAIT the pushed
  // word was the outstanding request, so no separate in-flight term is needed.
  assign count_after = fifo_count + CW'(push) - CW'(pop);
  assign credit      = (count_after < FULL);

  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      imem_addr_q  <= RESET_PC;
      imem_req_q   <= 1'b0;
    end else if (redirect) begin
      fetch_pc_q <= target;
      imem_req_q <= 1'b0;
      unique case (state_q)
        IDLE: state_q <= IDLE;
        REQ:  state_q <= gnt ? DROP : REQ;
        WAIT, DROP: begin
          // An ack in the redirect cycle retires the stale request immediately.
          if (ack) begin
            state_q     <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= target;
          end else begin
            state_q <= DROP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (credit) begin
            state_q     <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_pc_q;
          end
        end
        REQ: begin
          // imem_req is low here only for the cycle after a redirect dropped it.
          if (!imem_req_q) begin
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_pc_q;
          end else if (gnt) begin
            state_q      <= WAIT;
            imem_req_q   <= 1'b0;
            pending_pc_q <= fetch_pc_q;
          end
        end
        WAIT: begin
          if (ack) begin
            fetch_pc_q <= fetch_pc_inc;
            if (credit) begin
              state_q     <= REQ;
              imem_req_q  <= 1'b1;
              imem_addr_q <= fetch_pc_inc;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DROP: begin
          if (ack) begin
            state_q     <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_pc_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.inst_valid = inst_valid;
  assign bus.inst       = fifo_head.inst;
  assign bus.inst_pc    = fifo_head.pc;
  assign bus.inst_pc4   = next_pc(fifo_head.pc);
  assign dbg_state_o    = state_q;

`ifdef PREFETCH_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.inst_ready && !inst_valid && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
